// File: rtl/div_iter_if.sv
// -----------------------------------------------------------------------------
// div_iter_if
// Bundles the request/response signals between the EX-stage control logic and
// the iterative divider.
//
//   start     request a division (honoured only while the divider is idle)
//   is_signed 1 = DIV (signed), 0 = DIVU
//   flush     abandon any in-flight division
//   a, b      dividend / divisor, captured together with start
//   stall_o   pipeline stall request from the divider
//   valid_o   one-cycle pulse marking result_o as valid
//   result_o  {remainder, quotient}
//
// master: the pipeline side that issues requests.
// slave : the divider.
// -----------------------------------------------------------------------------
interface div_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start;
    logic                 is_signed;
    logic                 flush;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 stall_o;
    logic                 valid_o;
    logic [2*WIDTH-1:0]   result_o;

    modport master (
        output start, is_signed, flush, a, b,
        input  stall_o, valid_o, result_o
    );

    modport slave (
        input  start, is_signed, flush, a, b,
        output stall_o, valid_o, result_o
    );
endinterface

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter
// Iterative radix-2 restoring divider for DIV/DIVU. One quotient bit is
// produced per cycle; the signed case divides magnitudes and fixes the signs
// on the way out. Result is {remainder, quotient} (HI = remainder, LO =
// quotient).
//
// Ports:
//   clk  clock, all state changes on the rising edge
//   rst  asynchronous, active-high reset
//   bus  div_iter_if slave modport (start/is_signed/flush/a/b in,
//        stall_o/valid_o/result_o out)
// -----------------------------------------------------------------------------
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    div_iter_if.slave     bus
);

    // One extra bit so the counter can represent WIDTH without wrapping.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t             state;
    state_t             state_nx;

    logic [WIDTH-1:0]   rem_q;      // partial remainder
    logic [WIDTH-1:0]   quo_q;      // dividend, shifted out as quotient shifts in
    logic [WIDTH-1:0]   dsr_q;      // divisor magnitude
    logic [CW-1:0]      cnt_q;
    logic               q_neg;      // negate quotient in DONE
    logic               r_neg;      // negate remainder in DONE
    logic               flush_d;    // flush seen in the previous cycle
    logic [2*WIDTH-1:0] result_q;   // last delivered result, held while idle

    // ---------------------------------------------------------------------
    // Operand preparation
    // ---------------------------------------------------------------------
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               b_zero;

    assign a_neg  = bus.is_signed & bus.a[WIDTH-1];
    assign b_neg  = bus.is_signed & bus.b[WIDTH-1];
    assign a_mag  = a_neg ? -bus.a : bus.a;
    assign b_mag  = b_neg ? -bus.b : bus.b;
    assign b_zero = (bus.b == '0);

    // ---------------------------------------------------------------------
    // One restoring step
    // ---------------------------------------------------------------------
    // The shifted remainder needs WIDTH+1 bits: it can reach 2*|b|-1, which
    // exceeds WIDTH bits when |b| has its top bit set (e.g. unsigned 0xFFFFFFFF).
    logic [WIDTH:0]     rem_sh;
    logic               q_bit;
    logic [WIDTH-1:0]   rem_step;
    logic [WIDTH-1:0]   quo_step;
    logic               last_step;

    assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
    assign q_bit     = (rem_sh >= {1'b0, dsr_q});
    // When the trial subtraction succeeds the difference is below |b|, so it
    // always fits in WIDTH bits and the truncation loses nothing.
    assign rem_step  = q_bit ? WIDTH'(rem_sh - {1'b0, dsr_q}) : rem_sh[WIDTH-1:0];
    assign quo_step  = {quo_q[WIDTH-2:0], q_bit};
    assign last_step = (cnt_q == CW'(WIDTH - 1));

    // ---------------------------------------------------------------------
    // Sign correction, applied combinationally while in DONE
    // ---------------------------------------------------------------------
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign quo_fix = q_neg ? -quo_q : quo_q;
    assign rem_fix = r_neg ? -rem_q : rem_q;

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state logic
    // ---------------------------------------------------------------------
    // NOTE: state_nx gets a default before any branch; without it a missed
    // path would hold the old value and infer a latch.
    always_comb begin
        state_nx = state;
        if (bus.flush) begin
            state_nx = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state_nx = b_zero ? DONE : CALC;
                    end
                end
                CALC: begin
                    if (last_step) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            cnt_q    <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            flush_d  <= 1'b0;
            result_q <= '0;
        end else begin
            flush_d <= bus.flush;
            if (bus.flush) begin
                cnt_q <= '0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (bus.start) begin
                            cnt_q <= '0;
                            dsr_q <= b_mag;
                            if (b_zero) begin
                                // Divide by zero: raw dividend as remainder,
                                // all-ones quotient, no sign fix-up.
                                rem_q <= bus.a;
                                quo_q <= '1;
                                q_neg <= 1'b0;
                                r_neg <= 1'b0;
                            end else begin
                                rem_q <= '0;
                                quo_q <= a_mag;
                                q_neg <= a_neg ^ b_neg;
                                r_neg <= a_neg;
                            end
                        end
                    end
                    CALC: begin
                        rem_q <= rem_step;
                        quo_q <= quo_step;
                        cnt_q <= cnt_q + CW'(1);
                    end
                    DONE: begin
                        result_q <= {rem_fix, quo_fix};
                    end
                    default: begin
                        cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    // Stall drops in DONE so the pipeline captures the result and advances in
    // the same cycle.
    assign bus.stall_o  = ~bus.flush &
                          (((state == IDLE) & bus.start) | (state == CALC));
    assign bus.valid_o  = (state == DONE) & ~bus.flush & ~flush_d;
    // In DONE the fixed-up value is shown directly; otherwise the last
    // delivered result is held.
    assign bus.result_o = bus.valid_o ? {rem_fix, quo_fix} : result_q;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter
// Self-checking bench for div_iter. Stimulus pushes the hand-computed result
// and the cycle in which valid_o must appear into a scoreboard queue; an
// independent monitor pops and compares on every valid_o pulse.
// -----------------------------------------------------------------------------
module tb_div_iter;

    localparam int W = 32;

    typedef struct {
        logic [2*W-1:0] res;
        int             cyc;
        string          nm;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   c0;

    exp_t sb[$];
    exp_t e;

    div_iter_if #(.WIDTH(W)) bus ();

    div_iter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle starting now (just after a rising edge).
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic push,
                         input logic [2*W-1:0] res, input int lat,
                         input string nm);
        bus.a         = a;
        bus.b         = b;
        bus.is_signed = s;
        bus.start     = 1'b1;
        if (push) sb.push_back('{res, cyc + lat, nm});
        @(negedge clk);
        check({nm, " stall at start"}, 64'(bus.stall_o), 64'd1);
        tick();
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for all expected results to be delivered.
    task automatic drain();
        for (int i = 0; i < 80 && sb.size() != 0; i++) tick();
        check("drain pending results", 64'(sb.size()), 64'd0);
        tick();
    endtask

    // Monitor: every valid_o pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (bus.valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected valid_o", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.nm, " result"}, bus.result_o, e.res);
                check({e.nm, " valid cycle"}, 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.start     = 1'b0;
        bus.is_signed = 1'b0;
        bus.flush     = 1'b0;
        bus.a         = '0;
        bus.b         = '0;

        // Reset state
        #2;
        check("reset stall_o",  64'(bus.stall_o),  64'd0);
        check("reset valid_o",  64'(bus.valid_o),  64'd0);
        check("reset result_o", bus.result_o,      64'd0);
        #10;
        rst = 1'b0;
        tick();

        // 1. Unsigned 100/7: stall through cycle 32, valid in cycle 33
        issue(32'd100, 32'd7, 1'b0, 1'b1, {32'd2, 32'd14}, 33, "u100div7");
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            check("u100div7 stall", 64'(bus.stall_o), 64'(k <= 32));
        end
        drain();

        // 2. Signed sign combinations
        issue(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, "s-7div2");
        drain();
        issue(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, {32'h0000_0001, 32'hFFFF_FFFD}, 33, "s7div-2");
        drain();
        issue(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 1'b1, {32'hFFFF_FFFF, 32'h0000_0003}, 33, "s-7div-2");
        drain();

        // 3. Overflow and extremes
        issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, {32'h0, 32'h8000_0000}, 33, "s_ovf");
        drain();
        issue(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b1, {32'h0, 32'hFFFF_FFFF}, 33, "u_max_div1");
        drain();
        issue(32'd5, 32'd9, 1'b0, 1'b1, {32'd5, 32'd0}, 33, "u5div9");
        drain();

        // 4. Divide by zero, unsigned and signed (raw values, no sign fix)
        issue(32'h1234, 32'd0, 1'b0, 1'b1, {32'h1234, 32'hFFFF_FFFF}, 1, "u_div0");
        @(negedge clk);
        check("u_div0 stall in cycle 1", 64'(bus.stall_o), 64'd0);
        drain();
        issue(32'hFFFF_FFF9, 32'd0, 1'b1, 1'b1, {32'hFFFF_FFF9, 32'hFFFF_FFFF}, 1, "s_div0");
        drain();

        // 5. Flush in cycle 10, then a new 20/3 in cycle 11
        c0 = cyc;
        issue(32'd100, 32'd7, 1'b0, 1'b0, '0, 0, "flushed");
        while (cyc < c0 + 10) tick();
        bus.flush = 1'b1;
        @(negedge clk);
        check("flush stall_o low", 64'(bus.stall_o), 64'd0);
        tick();
        bus.flush = 1'b0;
        #1;
        check("idle after flush", 64'(bus.stall_o), 64'd0);
        issue(32'd20, 32'd3, 1'b0, 1'b1, {32'd2, 32'd6}, 33, "u20div3");
        drain();

        // flush together with start in IDLE: start ignored
        bus.a         = 32'd1;
        bus.b         = 32'd0;
        bus.is_signed = 1'b0;
        bus.start     = 1'b1;
        bus.flush     = 1'b1;
        #1;
        check("flush+start stall_o", 64'(bus.stall_o), 64'd0);
        tick();
        bus.start = 1'b0;
        bus.flush = 1'b0;
        #1;
        check("flush+start not accepted", 64'(bus.stall_o), 64'd0);
        repeat (3) tick();

        // 6. Async reset mid-CALC, then 9/3 with an ignored start at cycle 5
        issue(32'd100, 32'd7, 1'b0, 1'b0, '0, 0, "reset_abort");
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async rst stall_o",  64'(bus.stall_o), 64'd0);
        check("async rst valid_o",  64'(bus.valid_o), 64'd0);
        check("async rst result_o", bus.result_o,     64'd0);
        tick();
        #2;
        rst = 1'b0;
        tick();
        c0 = cyc;
        issue(32'd9, 32'd3, 1'b0, 1'b1, {32'd0, 32'd3}, 33, "u9div3");
        while (cyc < c0 + 5) tick();
        bus.a     = 32'd1;
        bus.b     = 32'd1;
        bus.start = 1'b1;
        #1;
        check("start in CALC stall_o", 64'(bus.stall_o), 64'd1);
        tick();
        bus.start = 1'b0;
        drain();

        // Result held while idle
        @(negedge clk);
        check("result held in IDLE", bus.result_o, {32'd0, 32'd3});
        check("valid_o low in IDLE", 64'(bus.valid_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Iterative radix-2 restoring divider for the EX stage; executes DIV/DIVU when the ALU control decoder emits DIV_CONTROL.
- Produces a 64-bit {remainder, quotient} result that the HI/LO register file writes as HI = remainder, LO = quotient.
- Stalls the pipeline while it works.
- Accepts a flush from the exception logic to abandon an in-flight division.

Parameters:
WIDTH  32  operand width; the result is 2*WIDTH.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a division; sampled only in IDLE
is_signed  input  1  1 = DIV (signed), 0 = DIVU; latched with start
flush  input  1  abandon the current operation (exception or branch flush)
a  input  WIDTH  dividend; latched with start
b  input  WIDTH  divisor; latched with start
stall_o  output  1  pipeline stall request
valid_o  output  1  one-cycle pulse; result_o is valid while it is high
result_o  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state = IDLE, counter = 0, internal registers = 0, valid_o = 0, result_o = 0, stall_o = 0.
- States: IDLE, CALC, DONE.
- IDLE -> CALC, when start=1, flush=0 and b != 0:
  - Latch |a| and |b|; use two's-complement magnitudes when is_signed=1, raw values otherwise.
  - Latch the quotient-negate flag (a[MSB]^b[MSB])&is_signed.
  - Latch the remainder-negate flag a[MSB]&is_signed.
  - Clear the partial remainder and set the counter to 0.
- IDLE -> DONE, when start=1, flush=0 and b == 0:
  - Latch quotient = all ones and remainder = a, unsigned/raw, with no sign correction.
  - valid_o is asserted on the next cycle.
- CALC:
  - Each cycle does one restoring step: shift {rem, dividend} left by 1; trial = rem - |b|; if trial is non-negative, rem = trial and the shifted-in quotient bit is 1, else 0.
  - The counter increments every cycle. After the step with counter = WIDTH-1, go to DONE.
- DONE:
  - Apply the sign fixes: negate the quotient if the quotient flag is set; negate the remainder if the remainder flag is set.
  - Drive result_o and pulse valid_o = 1 for exactly this cycle, then go to IDLE.
  - result_o holds its value in IDLE until the next DONE.
- Latency (start accepted in cycle 0, normal divisor): CALC covers cycles 1..WIDTH; valid_o = 1 in cycle WIDTH+1 (cycle 33 for WIDTH=32). Divide by zero: valid_o = 1 in cycle 1.
- stall_o is combinational: (state==IDLE & start & ~flush) | (state==CALC). It is low in DONE so the pipeline advances in the same cycle it captures the result.
- Signed overflow: -2^(W-1) / -1 gives quotient 0x80000000 and remainder 0 (wraps); no trap is raised.
- start while in CALC or DONE: ignored; operands are not re-latched.
- flush:
  - In any state, the next state is IDLE and the counter is cleared.
  - valid_o is forced to 0 in that cycle and the following one.
  - stall_o is 0 while flush = 1.
  - flush and start together in IDLE: start is ignored.
- rst during CALC: immediate return to the reset values; no valid_o pulse.
- No back-to-back overlap: a new start is accepted no earlier than the IDLE cycle after DONE.

Test Plan:
1. Unsigned: a=100, b=7, is_signed=0, start in cycle 0 -> stall_o high in cycles 0..32; valid_o high only in cycle 33; result_o = {32'd2, 32'd14}.
2. Signed: a=-7 (0xFFFFFFF9), b=2, is_signed=1 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Then a=7, b=-2 -> quotient 0xFFFFFFFD, remainder 1.
3. Overflow and extremes:
   - Signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0.
   - Unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0.
   - Unsigned 5 / 9 -> quotient 0, remainder 5.
4. Divide by zero: a=0x1234, b=0, start in cycle 0 -> valid_o in cycle 1; result_o = {32'h1234, 32'hFFFFFFFF}; stall_o high only in cycle 0.
5. Flush mid-operation: start in cycle 0, flush=1 in cycle 10 -> stall_o = 0 in cycle 10; state IDLE in cycle 11; no valid_o pulse in cycles 10..40. A new start (20/3) in cycle 11 -> valid_o in cycle 44 with {2, 6}.
6. Async reset and ignored start:
   - rst asserted mid-CALC, between clock edges -> outputs go to 0 immediately, without waiting for a clock edge.
   - After release, start with 9/3 -> {0, 3} at +33 cycles.
   - A start pulse at cycle 5 of that run is ignored; the result is unchanged.
